// File: rtl/keccak_pkg.sv
// Shared Keccak constants, lane extraction helper and squeeze FSM encoding.
package keccak_pkg;

    localparam int LANE_W    = 64;
    localparam int NUM_LANES = 25;
    localparam int STATE_W   = 1600;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EMIT      = 2'd1,
        WAIT_PERM = 2'd2
    } squeeze_state_t;

    // Lane k (k = x + 5y) sits at the top of the string for k = 0.
    function automatic logic [LANE_W-1:0] lane_of(input logic [STATE_W-1:0] state, input int k);
        return state[STATE_W-1-LANE_W*k -: LANE_W];
    endfunction

endpackage

// File: rtl/keccak_squeeze_if.sv
// State-in / lane-out bundle between the round core, the squeezer and the digest sink.
interface keccak_squeeze_if;
    import keccak_pkg::*;

    logic [STATE_W-1:0] state_in;
    logic               state_valid;
    logic               state_ready;
    logic               perm_req;
    logic [LANE_W-1:0]  out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               busy;

    // Driver side: supplies states and consumes lanes.
    modport master (
        output state_in, state_valid, out_ready,
        input  state_ready, perm_req, out_data, out_valid, out_last, busy
    );

    // Squeezer side.
    modport slave (
        input  state_in, state_valid, out_ready,
        output state_ready, perm_req, out_data, out_valid, out_last, busy
    );

endinterface

// File: rtl/keccak_squeeze.sv
// Captures the rate part of a permuted Keccak state and streams it lane by
// lane, requesting further permutations until OUT_LANES lanes are delivered.
module keccak_squeeze
    import keccak_pkg::*;
#(
    parameter int RATE_LANES = 17,
    parameter int OUT_LANES  = 4,
    parameter int CNT_W      = 16
) (
    input  logic            clk,
    input  logic            rst,
    keccak_squeeze_if.slave bus
);

    localparam int IDX_W = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_LANES - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUT_LANES - 1);

    squeeze_state_t     r_state;
    logic [IDX_W-1:0]   r_lane_idx;
    logic [CNT_W-1:0]   r_total;
    logic [LANE_W-1:0]  r_buf [RATE_LANES];
    logic [LANE_W-1:0]  r_out_data;
    logic               r_out_valid;
    logic               r_out_last;
    logic               r_perm_req;

    logic               w_accept;
    logic               w_xfer;
    logic [IDX_W-1:0]   w_next_idx;
    logic [CNT_W-1:0]   w_next_total;

    // A state is taken whenever the block is not emitting.
    assign w_accept     = bus.state_valid && bus.state_ready;
    assign w_xfer       = r_out_valid && bus.out_ready;
    assign w_next_idx   = r_lane_idx + IDX_W'(1);
    assign w_next_total = r_total + CNT_W'(1);

    assign bus.state_ready = (r_state != EMIT);
    assign bus.busy        = (r_state != IDLE);
    assign bus.perm_req    = r_perm_req;
    assign bus.out_data    = r_out_data;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_last    = r_out_last;

    // Rate lanes only; capacity lanes are never stored.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < RATE_LANES; k++) begin
                r_buf[k] <= lane_of(bus.state_in, k);
            end
        end
    end

    // Squeeze FSM with registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lane_idx  <= '0;
            r_total     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_perm_req  <= 1'b0;
        end else begin
            r_perm_req <= 1'b0;
            case (r_state)
                IDLE, WAIT_PERM: begin
                    if (bus.state_valid) begin
                        r_state     <= EMIT;
                        r_lane_idx  <= '0;
                        r_out_data  <= lane_of(bus.state_in, 0);
                        r_out_valid <= 1'b1;
                        // A fresh squeeze restarts the count; a re-permuted
                        // block continues where the previous one stopped.
                        if (r_state == IDLE) begin
                            r_total    <= '0;
                            r_out_last <= (OUT_LANES == 1);
                        end else begin
                            r_out_last <= (r_total == LAST_CNT);
                        end
                    end
                end
                EMIT: begin
                    if (w_xfer) begin
                        if (r_out_last) begin
                            r_state     <= IDLE;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end else if (r_lane_idx != LAST_IDX) begin
                            r_lane_idx <= w_next_idx;
                            r_total    <= w_next_total;
                            r_out_data <= r_buf[w_next_idx];
                            r_out_last <= (w_next_total == LAST_CNT);
                        end else begin
                            // Rate block exhausted before the digest is complete.
                            r_state     <= WAIT_PERM;
                            r_lane_idx  <= '0;
                            r_total     <= w_next_total;
                            r_out_valid <= 1'b0;
                            r_perm_req  <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_squeeze.sv
// Directed bench for keccak_squeeze: SHA3-256 defaults, a multi-block
// (RATE_LANES=2, OUT_LANES=5) instance and a full-width (25/25) instance.
module tb_keccak_squeeze;
    import keccak_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    keccak_squeeze_if if0 ();
    keccak_squeeze_if if1 ();
    keccak_squeeze_if if2 ();

    keccak_squeeze #(.RATE_LANES(17), .OUT_LANES(4), .CNT_W(16)) u_def (
        .clk(clk), .rst(rst), .bus(if0.slave));
    keccak_squeeze #(.RATE_LANES(2), .OUT_LANES(5), .CNT_W(16)) u_multi (
        .clk(clk), .rst(rst), .bus(if1.slave));
    keccak_squeeze #(.RATE_LANES(25), .OUT_LANES(25), .CNT_W(16)) u_full (
        .clk(clk), .rst(rst), .bus(if2.slave));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [STATE_W-1:0] mk_state(input logic [63:0] base);
        logic [STATE_W-1:0] s;
        s = '0;
        for (int k = 0; k < NUM_LANES; k++) s[STATE_W-1-LANE_W*k -: LANE_W] = base + 64'(k + 1);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transfer and perm_req monitors (sampled mid-cycle).
    logic [63:0] q1 [$];
    bit          l1 [$];
    int          perm1_at [$];
    logic [63:0] q2 [$];
    bit          l2 [$];
    int perm0_cnt = 0, perm1_cnt = 0, perm2_cnt = 0, perm1_long = 0;
    bit perm1_prev = 1'b0;

    always @(negedge clk) begin
        if (if0.perm_req) perm0_cnt++;
        if (if2.perm_req) perm2_cnt++;
        if (if1.perm_req) begin
            perm1_cnt++;
            perm1_at.push_back(q1.size());
            if (perm1_prev) perm1_long++;
        end
        perm1_prev = if1.perm_req;
        if (if1.out_valid && if1.out_ready) begin
            q1.push_back(if1.out_data);
            l1.push_back(if1.out_last);
        end
        if (if2.out_valid && if2.out_ready) begin
            q2.push_back(if2.out_data);
            l2.push_back(if2.out_last);
        end
    end

    typedef struct {
        bit          sv;
        bit          rdy;
        bit          ev;
        logic [63:0] ed;
        bit          el;
        bit          esr;
    } vec_t;

    vec_t tv [0:13];

    initial begin
        logic [STATE_W-1:0] st0;
        logic [STATE_W-1:0] st_aa;
        logic [STATE_W-1:0] st2;
        int  nst;
        bit  done;

        // Scenarios 1 and 2 back to back: full-rate squeeze, then backpressure 0,0,1,0,1,1,1.
        tv[0]  = '{1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1};
        tv[1]  = '{1'b0, 1'b1, 1'b1, 64'd1, 1'b0, 1'b0};
        tv[2]  = '{1'b0, 1'b1, 1'b1, 64'd2, 1'b0, 1'b0};
        tv[3]  = '{1'b0, 1'b1, 1'b1, 64'd3, 1'b0, 1'b0};
        tv[4]  = '{1'b0, 1'b1, 1'b1, 64'd4, 1'b1, 1'b0};
        tv[5]  = '{1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1};
        tv[6]  = '{1'b0, 1'b0, 1'b1, 64'd1, 1'b0, 1'b0};
        tv[7]  = '{1'b0, 1'b0, 1'b1, 64'd1, 1'b0, 1'b0};
        tv[8]  = '{1'b0, 1'b1, 1'b1, 64'd1, 1'b0, 1'b0};
        tv[9]  = '{1'b0, 1'b0, 1'b1, 64'd2, 1'b0, 1'b0};
        tv[10] = '{1'b0, 1'b1, 1'b1, 64'd2, 1'b0, 1'b0};
        tv[11] = '{1'b0, 1'b1, 1'b1, 64'd3, 1'b0, 1'b0};
        tv[12] = '{1'b0, 1'b1, 1'b1, 64'd4, 1'b1, 1'b0};
        tv[13] = '{1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1};

        st0 = mk_state(64'd0);
        st_aa = st0;
        st_aa[STATE_W-1 -: LANE_W] = 64'hAA;
        st2 = st0;
        st2[LANE_W-1:0] = 64'hDEADBEEF;

        if0.state_in = st0;  if0.state_valid = 1'b0; if0.out_ready = 1'b0;
        if1.state_in = '0;   if1.state_valid = 1'b0; if1.out_ready = 1'b0;
        if2.state_in = '0;   if2.state_valid = 1'b0; if2.out_ready = 1'b0;

        // Reset state.
        tick(); tick();
        chk("rst out_valid", {63'd0, if0.out_valid}, 64'd0);
        chk("rst out_last", {63'd0, if0.out_last}, 64'd0);
        chk("rst out_data", if0.out_data, 64'd0);
        chk("rst perm_req", {63'd0, if0.perm_req}, 64'd0);
        chk("rst state_ready", {63'd0, if0.state_ready}, 64'd1);
        chk("rst busy", {63'd0, if0.busy}, 64'd0);
        chk("rst multi ready", {63'd0, if1.state_ready}, 64'd1);
        rst = 1'b0;

        // Table-driven part.
        for (int i = 0; i < 14; i++) begin
            if0.state_valid = tv[i].sv;
            if0.out_ready   = tv[i].rdy;
            chk($sformatf("tv%0d valid", i), {63'd0, if0.out_valid}, {63'd0, tv[i].ev});
            if (tv[i].ev) chk($sformatf("tv%0d data", i), if0.out_data, tv[i].ed);
            chk($sformatf("tv%0d last", i), {63'd0, if0.out_last}, {63'd0, tv[i].el});
            chk($sformatf("tv%0d state_ready", i), {63'd0, if0.state_ready}, {63'd0, tv[i].esr});
            chk($sformatf("tv%0d busy", i), {63'd0, if0.busy}, {63'd0, ~tv[i].esr});
            tick();
        end

        // Scenario 4: a state offered while emitting must be ignored.
        if0.state_valid = 1'b1; if0.out_ready = 1'b0;
        tick();
        if0.state_in = st_aa;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy%0d state_ready", i), {63'd0, if0.state_ready}, 64'd0);
            chk($sformatf("busy%0d data", i), if0.out_data, 64'd1);
            tick();
        end
        if0.state_valid = 1'b0; if0.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("busy drain%0d data", i), if0.out_data, 64'(i + 1));
            chk($sformatf("busy drain%0d state_ready", i), {63'd0, if0.state_ready}, 64'd0);
            tick();
        end
        chk("busy end valid", {63'd0, if0.out_valid}, 64'd0);
        if0.state_in = st0;

        // Scenario 5: reset after beat 2.
        if0.state_valid = 1'b1;
        tick();
        if0.state_valid = 1'b0;
        tick(); tick();
        chk("pre-rst data", if0.out_data, 64'd3);
        rst = 1'b1;
        tick();
        chk("midrst valid", {63'd0, if0.out_valid}, 64'd0);
        chk("midrst last", {63'd0, if0.out_last}, 64'd0);
        chk("midrst perm", {63'd0, if0.perm_req}, 64'd0);
        chk("midrst state_ready", {63'd0, if0.state_ready}, 64'd1);
        chk("midrst busy", {63'd0, if0.busy}, 64'd0);
        rst = 1'b0;
        if0.state_valid = 1'b1;
        tick();
        if0.state_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("post-rst%0d valid", i), {63'd0, if0.out_valid}, 64'd1);
            chk($sformatf("post-rst%0d data", i), if0.out_data, 64'(i + 1));
            chk($sformatf("post-rst%0d last", i), {63'd0, if0.out_last}, {63'd0, i == 3});
            tick();
        end
        chk("post-rst idle", {63'd0, if0.state_ready}, 64'd1);

        // Scenario 3: multi-block squeeze; the next state is offered in the perm_req cycle.
        if1.state_in = mk_state(64'd0); if1.state_valid = 1'b1; if1.out_ready = 1'b1;
        nst = 1; done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            tick();
            if (if1.perm_req) begin
                chk("multi perm state_ready", {63'd0, if1.state_ready}, 64'd1);
                if1.state_in = mk_state(nst == 1 ? 64'd10 : 64'd20);
                nst++;
                if1.state_valid = 1'b1;
            end else if (if1.busy && if1.out_valid) begin
                if1.state_valid = 1'b0;
            end
            if (q1.size() >= 5 && !if1.out_valid && !if1.busy) done = 1'b1;
        end
        if1.state_valid = 1'b0;
        chk("multi finished", {63'd0, done}, 64'd1);
        chk("multi beats", 64'(q1.size()), 64'd5);
        for (int i = 0; i < 5 && i < q1.size(); i++) begin
            logic [63:0] e;
            e = (i < 2) ? 64'(i + 1) : (i < 4) ? 64'(i + 9) : 64'd21;
            chk($sformatf("multi beat%0d data", i), q1[i], e);
            chk($sformatf("multi beat%0d last", i), {63'd0, l1[i]}, {63'd0, i == 4});
        end
        chk("multi perm count", 64'(perm1_cnt), 64'd2);
        chk("multi perm width", 64'(perm1_long), 64'd0);
        if (perm1_at.size() >= 2) begin
            chk("multi perm1 after", 64'(perm1_at[0]), 64'd2);
            chk("multi perm2 after", 64'(perm1_at[1]), 64'd4);
        end

        // Scenario 6: all 25 lanes are rate; lane 24 is the final beat.
        if2.state_in = st2; if2.state_valid = 1'b1; if2.out_ready = 1'b1;
        tick();
        if2.state_valid = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            tick();
            if (q2.size() >= 25 && !if2.busy) done = 1'b1;
        end
        chk("full finished", {63'd0, done}, 64'd1);
        chk("full beats", 64'(q2.size()), 64'd25);
        for (int i = 0; i < 25 && i < q2.size(); i++) begin
            chk($sformatf("full beat%0d data", i), q2[i], (i == 24) ? 64'hDEADBEEF : 64'(i + 1));
            chk($sformatf("full beat%0d last", i), {63'd0, l2[i]}, {63'd0, i == 24});
        end
        chk("full perm count", 64'(perm2_cnt), 64'd0);
        chk("default perm count", 64'(perm0_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
